count_seq_ctrl: RTL and testbench



---
 rtl/count_seq_ctrl.sv | 197 +++++++++++++++++++
 tb/tb_count_seq_ctrl.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/count_seq_ctrl.sv
// count_seq_ctrl
//   Sequencer for a single-digit counter/display path. Debounced buttons and
//   switches pass a 2-flop synchronizer. Rising edges of the synchronized
//   buttons drive an IDLE/RUN/PAUSE state machine. The state machine steps a
//   modulo-MOD up/down counter, either from a prescaler tick (RUN) or from
//   manual step presses (IDLE/PAUSE).
//
//   Ports
//     clk       system clock, all state on posedge
//     reset     asynchronous active-low reset, clears all state
//     btn_run   debounced level, each rising edge toggles run/pause
//     btn_step  debounced level, each rising edge is one manual step
//     up        switch level, 1 = count up, 0 = count down
//     clear     switch level, while high count=0 and state=IDLE
//     count     current count value (WIDTH bits)
//     carry     one-cycle pulse after a wrapping step
//     running   high while in RUN
//     leds      active-low 7-segment pattern of count, leds[0]=a .. leds[6]=g
module count_seq_ctrl #(
    parameter int CLK_DIV = 50_000_000,
    parameter int MOD     = 10,
    parameter int WIDTH   = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             btn_run,
    input  logic             btn_step,
    input  logic             up,
    input  logic             clear,
    output logic [WIDTH-1:0] count,
    output logic             carry,
    output logic             running,
    output logic [6:0]       leds
);

    localparam int               PW       = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
    localparam logic [PW-1:0]    PRE_LAST = PW'(CLK_DIV - 1);
    localparam logic [WIDTH-1:0] CNT_LAST = WIDTH'(MOD - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_RUN   = 2'b01,
        ST_PAUSE = 2'b10
    } state_t;

    // One modulo step; the MSB of the result flags a wrap.
    function automatic logic [WIDTH:0] step_count(input logic [WIDTH-1:0] cur,
                                                  input logic             dir_up);
        logic [WIDTH:0] res;
        if (dir_up) begin
            if (cur == CNT_LAST) begin
                res = {1'b1, {WIDTH{1'b0}}};
            end else begin
                res = {1'b0, cur + WIDTH'(1)};
            end
        end else begin
            if (cur == {WIDTH{1'b0}}) begin
                res = {1'b1, CNT_LAST};
            end else begin
                res = {1'b0, cur - WIDTH'(1)};
            end
        end
        return res;
    endfunction

    // Hex digit to active-low segments, bit order g..a.
    function automatic logic [6:0] hex_to_seg(input logic [3:0] d);
        logic [6:0] seg;
        case (d)
            4'h0:    seg = 7'b1000000;
            4'h1:    seg = 7'b1111001;
            4'h2:    seg = 7'b0100100;
            4'h3:    seg = 7'b0110000;
            4'h4:    seg = 7'b0011001;
            4'h5:    seg = 7'b0010010;
            4'h6:    seg = 7'b0000010;
            4'h7:    seg = 7'b1111000;
            4'h8:    seg = 7'b0000000;
            4'h9:    seg = 7'b0010000;
            4'hA:    seg = 7'b0001000;
            4'hB:    seg = 7'b0000011;
            4'hC:    seg = 7'b1000110;
            4'hD:    seg = 7'b0100001;
            4'hE:    seg = 7'b0000110;
            4'hF:    seg = 7'b0001110;
            default: seg = 7'b1111111;
        endcase
        return seg;
    endfunction

    // Synchronizer bit order: [0]=btn_run [1]=btn_step [2]=up [3]=clear
    logic [3:0]       r_sync1;
    logic [3:0]       r_sync2;
    logic [1:0]       r_btn_prev;
    state_t           r_state;
    state_t           w_state_nxt;
    logic [PW-1:0]    r_presc;
    logic [PW-1:0]    w_presc_nxt;
    logic [WIDTH-1:0] r_count;
    logic [WIDTH-1:0] w_count_nxt;
    logic             r_carry;
    logic             w_carry_nxt;
    logic             r_running;
    logic             w_do_step;
    logic             w_run_edge;
    logic             w_step_edge;
    logic             w_clear;
    logic             w_up;
    logic [WIDTH:0]   w_step_res;
    logic [3:0]       w_digit;

    assign w_run_edge  = r_sync2[0] & ~r_btn_prev[0];
    assign w_step_edge = r_sync2[1] & ~r_btn_prev[1];
    assign w_up        = r_sync2[2];
    assign w_clear     = r_sync2[3];
    assign w_step_res  = step_count(r_count, w_up);

    // Input synchronizers and button edge-detect history.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_sync1    <= 4'b0000;
            r_sync2    <= 4'b0000;
            r_btn_prev <= 2'b00;
        end else begin
            r_sync1    <= {clear, up, btn_step, btn_run};
            r_sync2    <= r_sync1;
            r_btn_prev <= r_sync2[1:0];
        end
    end

    // Next-state, prescaler and counter update in priority order:
    // clear > run edge > step edge > tick.
    always_comb begin
        w_state_nxt = r_state;
        w_presc_nxt = r_presc;
        w_count_nxt = r_count;
        w_carry_nxt = 1'b0;
        w_do_step   = 1'b0;

        if (w_clear) begin
            w_state_nxt = ST_IDLE;
            w_presc_nxt = {PW{1'b0}};
            w_count_nxt = {WIDTH{1'b0}};
        end else if (w_run_edge) begin
            // Every entry to RUN restarts the prescaler so the first auto
            // step lands a full CLK_DIV cycles later; a coincident step
            // edge is dropped by falling through this branch.
            w_presc_nxt = {PW{1'b0}};
            case (r_state)
                ST_RUN:  w_state_nxt = ST_PAUSE;
                default: w_state_nxt = ST_RUN;
            endcase
        end else if (w_step_edge && (r_state != ST_RUN)) begin
            w_do_step = 1'b1;
        end else if (r_state == ST_RUN) begin
            if (r_presc == PRE_LAST) begin
                w_presc_nxt = {PW{1'b0}};
                w_do_step   = 1'b1;
            end else begin
                w_presc_nxt = r_presc + PW'(1);
            end
        end else begin
            w_presc_nxt = {PW{1'b0}};
        end

        if (w_do_step) begin
            w_count_nxt = w_step_res[WIDTH-1:0];
            w_carry_nxt = w_step_res[WIDTH];
        end else begin
            w_carry_nxt = 1'b0;
        end
    end

    // State, prescaler, count and registered status outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= ST_IDLE;
            r_presc   <= {PW{1'b0}};
            r_count   <= {WIDTH{1'b0}};
            r_carry   <= 1'b0;
            r_running <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_presc   <= w_presc_nxt;
            r_count   <= w_count_nxt;
            r_carry   <= w_carry_nxt;
            r_running <= (w_state_nxt == ST_RUN);
        end
    end

    assign w_digit = 4'(r_count);
    assign count   = r_count;
    assign carry   = r_carry;
    assign running = r_running;
    assign leds    = hex_to_seg(w_digit);

endmodule

// File: tb/tb_count_seq_ctrl.sv
// Bench for count_seq_ctrl: two instances (MOD=10 and MOD=16, CLK_DIV=4)
// share the stimulus. A behavioural model tracks each instance and is
// compared every falling edge; directed steps add hand-computed checks.
module tb_count_seq_ctrl;

    localparam int CDIV = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       btn_run = 1'b0;
    logic       btn_step = 1'b0;
    logic       up = 1'b1;
    logic       clear = 1'b0;
    logic [3:0] count10, count16;
    logic       carry10, carry16;
    logic       running10, running16;
    logic [6:0] leds10, leds16;

    int n_pass = 0;
    int n_total = 0;
    int carry_cnt10 = 0;

    count_seq_ctrl #(.CLK_DIV(CDIV), .MOD(10), .WIDTH(4)) u_dut10 (
        .clk(clk), .reset(reset), .btn_run(btn_run), .btn_step(btn_step),
        .up(up), .clear(clear), .count(count10), .carry(carry10),
        .running(running10), .leds(leds10)
    );

    count_seq_ctrl #(.CLK_DIV(CDIV), .MOD(16), .WIDTH(4)) u_dut16 (
        .clk(clk), .reset(reset), .btn_run(btn_run), .btn_step(btn_step),
        .up(up), .clear(clear), .count(count16), .carry(carry16),
        .running(running16), .leds(leds16)
    );

    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    // Mode: 0 idle, 1 run, 2 pause.
    int mods[2] = '{10, 16};
    int m_mode[2];
    int m_cnt[2];
    int m_car[2];
    int m_age[2];
    // Samples of each input taken at past edges: [0] previous edge, [1] two ago, [2] three ago.
    bit h_run[3];
    bit h_step[3];
    bit h_up[3];
    bit h_clr[3];

    function automatic logic [6:0] seg_of(input int v);
        // Lit segments (active high, g..a) for 0..F, inverted for the board.
        logic [6:0] lit[16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
        return ~lit[v & 15];
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_mode[i] = 0; m_cnt[i] = 0; m_car[i] = 0; m_age[i] = 0;
        end
        for (int j = 0; j < 3; j++) begin
            h_run[j] = 0; h_step[j] = 0; h_up[j] = 0; h_clr[j] = 0;
        end
    endtask

    task automatic model_step_count(input int i, input bit dir_up);
        if (dir_up) begin
            if (m_cnt[i] == mods[i] - 1) begin m_cnt[i] = 0; m_car[i] = 1; end
            else m_cnt[i] = m_cnt[i] + 1;
        end else begin
            if (m_cnt[i] == 0) begin m_cnt[i] = mods[i] - 1; m_car[i] = 1; end
            else m_cnt[i] = m_cnt[i] - 1;
        end
    endtask

    task automatic model_edge();
        // Actions at this edge see the input sampled two edges ago.
        bit run_e, step_e, clr, dir;
        run_e  = h_run[1] && !h_run[2];
        step_e = h_step[1] && !h_step[2];
        clr    = h_clr[1];
        dir    = h_up[1];
        for (int i = 0; i < 2; i++) begin
            m_car[i] = 0;
            if (clr) begin
                m_mode[i] = 0; m_cnt[i] = 0; m_age[i] = 0;
            end else if (run_e) begin
                m_mode[i] = (m_mode[i] == 1) ? 2 : 1;
                m_age[i] = 0;
            end else if (step_e && m_mode[i] != 1) begin
                model_step_count(i, dir);
            end else if (m_mode[i] == 1) begin
                m_age[i] = m_age[i] + 1;
                if (m_age[i] == CDIV) begin
                    m_age[i] = 0;
                    model_step_count(i, dir);
                end
            end
        end
        h_run[2] = h_run[1];   h_run[1] = h_run[0];   h_run[0] = btn_run;
        h_step[2] = h_step[1]; h_step[1] = h_step[0]; h_step[0] = btn_step;
        h_up[2] = h_up[1];     h_up[1] = h_up[0];     h_up[0] = up;
        h_clr[2] = h_clr[1];   h_clr[1] = h_clr[0];   h_clr[0] = clear;
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk or negedge reset);
            if (!reset) model_reset();
            else model_edge();
        end
    end

    // ---------------- checking helpers ----------------
    task automatic chk(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    function automatic int probe(input int inst, input int sel);
        if (inst == 0) return (sel == 0) ? int'(count10) : int'(carry10);
        else           return (sel == 0) ? int'(count16) : int'(carry16);
    endfunction

    // Every falling edge: both instances against the model.
    initial begin
        forever begin
            @(negedge clk);
            chk("m10_count",   count10,   m_cnt[0]);
            chk("m10_carry",   carry10,   m_car[0]);
            chk("m10_running", running10, (m_mode[0] == 1) ? 1 : 0);
            chk("m10_leds",    leds10,    seg_of(m_cnt[0]));
            chk("m16_count",   count16,   m_cnt[1]);
            chk("m16_carry",   carry16,   m_car[1]);
            chk("m16_running", running16, (m_mode[1] == 1) ? 1 : 0);
            chk("m16_leds",    leds16,    seg_of(m_cnt[1]));
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (carry10) carry_cnt10++;
        end
    end

    task automatic wait_until(input int inst, input int sel, input int val,
                              input int budget, input string name);
        bit hit = 0;
        for (int i = 0; i < budget && !hit; i++) begin
            @(negedge clk); #1;
            if (probe(inst, sel) == val) hit = 1;
        end
        chk(name, hit, 1);
    endtask

    task automatic press(input bit is_run);
        @(negedge clk);
        if (is_run) btn_run = 1'b1; else btn_step = 1'b1;
        repeat (3) @(negedge clk);
        btn_run = 1'b0; btn_step = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    // ---------------- directed stimulus ----------------
    initial begin
        int c0, c_pause;
        // Reset with no clock edge yet.
        #1 reset = 1'b0;
        #2;
        chk("rst_count", count10, 0);
        chk("rst_running", running10, 0);
        chk("rst_carry", carry10, 0);
        chk("rst_leds", leds10, 7'b1000000);
        @(negedge clk); reset = 1'b1;
        repeat (2) @(negedge clk);

        // 1. Run press, count up through the 9->0 wrap.
        @(negedge clk); btn_run = 1'b1;
        repeat (2) @(negedge clk); #1;
        chk("t1_running_before_k2", running10, 0);
        @(negedge clk); #1;
        chk("t1_running_at_k2", running10, 1);
        @(negedge clk); btn_run = 1'b0;
        wait_until(0, 1, 1, 80, "t1_wrap_carry");
        chk("t1_wrap_count", count10, 0);
        chk("t1_wrap_leds", leds10, 7'b1000000);

        // 2. Pause, then three manual down steps from 0.
        @(negedge clk); #1;
        c0 = carry_cnt10;
        btn_run = 1'b1; up = 1'b0;
        repeat (3) @(negedge clk);
        btn_run = 1'b0;
        repeat (3) @(negedge clk); #1;
        chk("t2_paused", running10, 0);
        chk("t2_count_held", count10, 0);
        repeat (3) press(1'b0);
        repeat (4) @(negedge clk); #1;
        chk("t2_count", count10, 7);
        chk("t2_running", running10, 0);
        chk("t2_carry_pulses", carry_cnt10 - c0, 1);

        // 3. Clear during RUN at count 5; presses ignored while clear high.
        up = 1'b1;
        press(1'b1);
        wait_until(0, 0, 5, 80, "t3_reach5");
        clear = 1'b1;
        repeat (3) @(negedge clk); #1;
        chk("t3_clear_count", count10, 0);
        chk("t3_clear_running", running10, 0);
        press(1'b1);
        press(1'b0);
        #1;
        chk("t3_ignored_count", count10, 0);
        chk("t3_ignored_running", running10, 0);
        clear = 1'b0;
        repeat (8) @(negedge clk); #1;
        chk("t3_stays_idle", running10, 0);
        chk("t3_stays_zero", count10, 0);

        // 4. Simultaneous run and step edges in PAUSE.
        press(1'b1);
        repeat (2) @(negedge clk);
        press(1'b1);
        repeat (2) @(negedge clk); #1;
        chk("t4_paused", running10, 0);
        c_pause = m_cnt[0];
        @(negedge clk); btn_run = 1'b1; btn_step = 1'b1;
        repeat (3) @(negedge clk); #1;
        chk("t4_running", running10, 1);
        chk("t4_count_unchanged", count10, c_pause);
        btn_run = 1'b0; btn_step = 1'b0;

        // 5. Asynchronous reset mid-RUN at count 6.
        wait_until(0, 0, 6, 80, "t5_reach6");
        #2 reset = 1'b0;
        #1;
        chk("t5_async_count", count10, 0);
        chk("t5_async_running", running10, 0);
        chk("t5_async_leds", leds10, 7'b1000000);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        repeat (10) @(negedge clk); #1;
        chk("t5_idle_after_release", running10, 0);
        chk("t5_zero_after_release", count10, 0);
        press(1'b1);
        chk("t5_run_again", running10, 1);

        // 6. MOD=16 digit patterns and F->0 wrap.
        wait_until(1, 0, 9, 200, "t6_reach9");
        chk("t6_leds9", leds16, 7'b0010000);
        wait_until(1, 0, 10, 10, "t6_reachA");
        chk("t6_ledsA", leds16, 7'b0001000);
        wait_until(1, 1, 1, 40, "t6_wrap_carry");
        chk("t6_wrap_count", count16, 0);

        repeat (2) @(negedge clk); #1;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
